// File: rtl/ex_mem_reg_pkg.sv
// Shared types for the EX/MEM pipeline register: the stage payload carried
// between EX and MEM, the byte-select codes and the payload reset value.
package ex_mem_reg_pkg;

   // Data fields are sized here; the register's DATA_W must not exceed this
   localparam int PAYLOAD_DATA_W = 32;

   typedef enum logic [1:0] {
      SEL_BYTE = 2'd0,
      SEL_HALF = 2'd1,
      SEL_WORD = 2'd2
   } byteSel_e;

   typedef struct packed {
      logic [PAYLOAD_DATA_W-1:0] aluResult;
      logic [PAYLOAD_DATA_W-1:0] wMemData;
      logic                      weMem;
      logic                      wRegDataSrc;
      byteSel_e                  wrMemByteSel;
      logic                      memReadDataExt;
      logic                      weReg;
      logic [4:0]                wRegAddr;
   } exMemPayload_t;

   localparam exMemPayload_t PAYLOAD_RESET = '0;

endpackage

// File: rtl/ex_mem_reg_skid.sv
// One-entry skid slot: a valid bit plus one stage payload, used to absorb the
// instruction accepted while the MEM side is stalled.
module pipe_skid_slot
   import ex_mem_reg_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          load,
   input  logic          unload,
   input  exMemPayload_t dataIn,
   output logic          valid,
   output exMemPayload_t dataOut
);

   // Clear wins over load so a flushed cycle never leaves a live entry behind
   always_ff @(posedge clock) begin
      if (reset) begin
         valid   <= 1'b0;
         dataOut <= PAYLOAD_RESET;
      end else begin
         if (clear)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (unload)
            valid <= 1'b0;
         if (load)
            dataOut <= dataIn;
      end
   end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush and a saturating
// back-pressure counter. Define EX_MEM_SKID_EN to add a one-entry skid buffer.
module ex_mem_reg
   import ex_mem_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_flush,
   input  logic              io_valid_EX,
   output logic              io_ready_EX,
   input  logic [DATA_W-1:0] io_aluResult_EX,
   input  logic [DATA_W-1:0] io_wMemData_EX,
   input  logic              io_weMEM_ctrl_EX,
   input  logic              io_wRegDataSrc_ctrl_EX,
   input  logic [1:0]        io_wrMemByteSelScr_ctrl_EX,
   input  logic              io_memReadDataExt_ctrl_EX,
   input  logic              io_weReg_ctrl_EX,
   input  logic [4:0]        io_wRegAddr_EX,
   output logic              io_valid_MEM,
   input  logic              io_ready_MEM,
   output logic [DATA_W-1:0] io_aluResult_MEM,
   output logic [DATA_W-1:0] io_wMemData_MEM,
   output logic              io_weMEM_ctrl_uMEM_MEM,
   output logic              io_wRegDataSrc_ctrl_uMEM_MEM,
   output logic [1:0]        io_wrMemByteSelScr_ctrl_uMEM_MEM,
   output logic              io_memReadDataExt_ctrl_uMEM_MEM,
   output logic              io_weReg_ctrl_MEM,
   output logic [4:0]        io_wRegAddr_MEM,
   output logic [CNT_W-1:0]  io_stallCnt
);

   exMemPayload_t inEntry;
   exMemPayload_t outEntry;
   logic          validMem;
   logic          upXfer;
   logic [CNT_W-1:0] stallCnt;

   always_comb begin
      inEntry                = PAYLOAD_RESET;
      inEntry.aluResult      = PAYLOAD_DATA_W'(io_aluResult_EX);
      inEntry.wMemData       = PAYLOAD_DATA_W'(io_wMemData_EX);
      inEntry.weMem          = io_weMEM_ctrl_EX;
      inEntry.wRegDataSrc    = io_wRegDataSrc_ctrl_EX;
      inEntry.wrMemByteSel   = byteSel_e'(io_wrMemByteSelScr_ctrl_EX);
      inEntry.memReadDataExt = io_memReadDataExt_ctrl_EX;
      inEntry.weReg          = io_weReg_ctrl_EX;
      inEntry.wRegAddr       = io_wRegAddr_EX;
   end

   assign upXfer = io_valid_EX & io_ready_EX;

`ifdef EX_MEM_SKID_EN
   logic          skidValid;
   exMemPayload_t skidEntry;
   logic          outFree;

   // Ready depends only on the skid register, never on io_ready_MEM
   assign io_ready_EX = ~skidValid;
   assign outFree     = ~validMem | io_ready_MEM;

   pipe_skid_slot uSkid (
      .clock   (clock),
      .reset   (reset),
      .clear   (io_flush),
      .load    (upXfer & ~outFree),
      .unload  (outFree),
      .dataIn  (inEntry),
      .valid   (skidValid),
      .dataOut (skidEntry)
   );

   // A freed output slot takes the older skid entry before any new arrival
   always_ff @(posedge clock) begin
      if (reset) begin
         validMem <= 1'b0;
         outEntry <= PAYLOAD_RESET;
      end else if (io_flush) begin
         validMem <= 1'b0;
      end else if (outFree) begin
         if (skidValid) begin
            validMem <= 1'b1;
            outEntry <= skidEntry;
         end else if (upXfer) begin
            validMem <= 1'b1;
            outEntry <= inEntry;
         end else begin
            validMem <= 1'b0;
         end
      end
   end
`else
   assign io_ready_EX = ~validMem | io_ready_MEM;

   // Flush drops both the held entry and any same-cycle arrival
   always_ff @(posedge clock) begin
      if (reset) begin
         validMem <= 1'b0;
         outEntry <= PAYLOAD_RESET;
      end else if (io_flush) begin
         validMem <= 1'b0;
      end else if (upXfer) begin
         validMem <= 1'b1;
         outEntry <= inEntry;
      end else if (io_ready_MEM) begin
         validMem <= 1'b0;
      end
   end
`endif

   // Counts stalled cycles and sticks at all-ones; flush leaves it alone
   always_ff @(posedge clock) begin
      if (reset)
         stallCnt <= '0;
      else if (validMem && !io_ready_MEM && stallCnt != '1)
         stallCnt <= stallCnt + CNT_W'(1);
   end

   assign io_valid_MEM                     = validMem;
   assign io_aluResult_MEM                 = outEntry.aluResult[DATA_W-1:0];
   assign io_wMemData_MEM                  = outEntry.wMemData[DATA_W-1:0];
   assign io_weMEM_ctrl_uMEM_MEM           = outEntry.weMem & validMem;
   assign io_wRegDataSrc_ctrl_uMEM_MEM     = outEntry.wRegDataSrc;
   assign io_wrMemByteSelScr_ctrl_uMEM_MEM = outEntry.wrMemByteSel;
   assign io_memReadDataExt_ctrl_uMEM_MEM  = outEntry.memReadDataExt;
   assign io_weReg_ctrl_MEM                = outEntry.weReg & validMem;
   assign io_wRegAddr_MEM                  = outEntry.wRegAddr;
   assign io_stallCnt                      = stallCnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: flow, stall, flush, bubble gating,
// counter saturation and reset, with hand-computed expectations.
module tb_ex_mem_reg;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_flush;
   logic        io_valid_EX;
   logic        io_ready_EX;
   logic [31:0] io_aluResult_EX;
   logic [31:0] io_wMemData_EX;
   logic        io_weMEM_ctrl_EX;
   logic        io_wRegDataSrc_ctrl_EX;
   logic [1:0]  io_wrMemByteSelScr_ctrl_EX;
   logic        io_memReadDataExt_ctrl_EX;
   logic        io_weReg_ctrl_EX;
   logic [4:0]  io_wRegAddr_EX;
   logic        io_valid_MEM;
   logic        io_ready_MEM;
   logic [31:0] io_aluResult_MEM;
   logic [31:0] io_wMemData_MEM;
   logic        io_weMEM_ctrl_uMEM_MEM;
   logic        io_wRegDataSrc_ctrl_uMEM_MEM;
   logic [1:0]  io_wrMemByteSelScr_ctrl_uMEM_MEM;
   logic        io_memReadDataExt_ctrl_uMEM_MEM;
   logic        io_weReg_ctrl_MEM;
   logic [4:0]  io_wRegAddr_MEM;
   logic [3:0]  io_stallCnt;

   int testCount = 0;
   int failCount = 0;

   ex_mem_reg #(.DATA_W(32), .CNT_W(4)) dut (
      .clock                            (clock),
      .reset                            (reset),
      .io_flush                         (io_flush),
      .io_valid_EX                      (io_valid_EX),
      .io_ready_EX                      (io_ready_EX),
      .io_aluResult_EX                  (io_aluResult_EX),
      .io_wMemData_EX                   (io_wMemData_EX),
      .io_weMEM_ctrl_EX                 (io_weMEM_ctrl_EX),
      .io_wRegDataSrc_ctrl_EX           (io_wRegDataSrc_ctrl_EX),
      .io_wrMemByteSelScr_ctrl_EX       (io_wrMemByteSelScr_ctrl_EX),
      .io_memReadDataExt_ctrl_EX        (io_memReadDataExt_ctrl_EX),
      .io_weReg_ctrl_EX                 (io_weReg_ctrl_EX),
      .io_wRegAddr_EX                   (io_wRegAddr_EX),
      .io_valid_MEM                     (io_valid_MEM),
      .io_ready_MEM                     (io_ready_MEM),
      .io_aluResult_MEM                 (io_aluResult_MEM),
      .io_wMemData_MEM                  (io_wMemData_MEM),
      .io_weMEM_ctrl_uMEM_MEM           (io_weMEM_ctrl_uMEM_MEM),
      .io_wRegDataSrc_ctrl_uMEM_MEM     (io_wRegDataSrc_ctrl_uMEM_MEM),
      .io_wrMemByteSelScr_ctrl_uMEM_MEM (io_wrMemByteSelScr_ctrl_uMEM_MEM),
      .io_memReadDataExt_ctrl_uMEM_MEM  (io_memReadDataExt_ctrl_uMEM_MEM),
      .io_weReg_ctrl_MEM                (io_weReg_ctrl_MEM),
      .io_wRegAddr_MEM                  (io_wRegAddr_MEM),
      .io_stallCnt                      (io_stallCnt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] wdata,
                                input logic weM, input logic weR, input logic [1:0] sel,
                                input logic [4:0] addr);
      io_valid_EX                = v;
      io_aluResult_EX            = alu;
      io_wMemData_EX             = wdata;
      io_weMEM_ctrl_EX           = weM;
      io_weReg_ctrl_EX           = weR;
      io_wrMemByteSelScr_ctrl_EX = sel;
      io_wRegAddr_EX             = addr;
   endtask

   // Directed scenario sequence
   initial begin
      reset                     = 1'b1;
      io_flush                  = 1'b0;
      io_ready_MEM              = 1'b0;
      io_wRegDataSrc_ctrl_EX    = 1'b0;
      io_memReadDataExt_ctrl_EX = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      tick();
      tick();
      checkOutput("rstValid", {31'b0, io_valid_MEM}, 32'h0);
      checkOutput("rstAlu", io_aluResult_MEM, 32'h0);
      checkOutput("rstCnt", {28'b0, io_stallCnt}, 32'h0);
      checkOutput("rstReady", {31'b0, io_ready_EX}, 32'h1);
      reset = 1'b0;

      io_ready_MEM = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, 32'(i * 16), 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
         tick();
         checkOutput("flowAlu", io_aluResult_MEM, 32'(i * 16));
         checkOutput("flowValid", {31'b0, io_valid_MEM}, 32'h1);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      tick();
      checkOutput("drainValid", {31'b0, io_valid_MEM}, 32'h0);
      checkOutput("drainHold", io_aluResult_MEM, 32'h30);

      applyStimulus(1'b1, 32'hA, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      tick();
      io_ready_MEM = 1'b0;
      applyStimulus(1'b1, 32'hB, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      #1;
`ifdef EX_MEM_SKID_EN
      checkOutput("stallReadyPre", {31'b0, io_ready_EX}, 32'h1);
`else
      checkOutput("stallReadyPre", {31'b0, io_ready_EX}, 32'h0);
`endif
      repeat (4) tick();
      checkOutput("stallAlu", io_aluResult_MEM, 32'hA);
      checkOutput("stallValid", {31'b0, io_valid_MEM}, 32'h1);
      checkOutput("stallCnt", {28'b0, io_stallCnt}, 32'h4);
      checkOutput("stallReady", {31'b0, io_ready_EX}, 32'h0);
      io_ready_MEM = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      tick();
`ifdef EX_MEM_SKID_EN
      checkOutput("skidOut", io_aluResult_MEM, 32'hB);
      checkOutput("skidValid", {31'b0, io_valid_MEM}, 32'h1);
      tick();
`endif
      checkOutput("releaseValid", {31'b0, io_valid_MEM}, 32'h0);

      applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 2'd0, 5'd0);
      tick();
      checkOutput("preFlushWe", {31'b0, io_weMEM_ctrl_uMEM_MEM}, 32'h1);
      io_flush = 1'b1;
      applyStimulus(1'b1, 32'h50, 32'h0, 1'b1, 1'b0, 2'd0, 5'd0);
      tick();
      io_flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      checkOutput("flushValid", {31'b0, io_valid_MEM}, 32'h0);
      checkOutput("flushWe", {31'b0, io_weMEM_ctrl_uMEM_MEM}, 32'h0);
      checkOutput("flushKeepsCnt", {28'b0, io_stallCnt}, 32'h4);

      io_wRegDataSrc_ctrl_EX    = 1'b1;
      io_memReadDataExt_ctrl_EX = 1'b1;
      applyStimulus(1'b1, 32'h55, 32'h1234, 1'b0, 1'b1, 2'd2, 5'd7);
      tick();
      checkOutput("fieldWeReg", {31'b0, io_weReg_ctrl_MEM}, 32'h1);
      checkOutput("fieldAddr", {27'b0, io_wRegAddr_MEM}, 32'h7);
      checkOutput("fieldSel", {30'b0, io_wrMemByteSelScr_ctrl_uMEM_MEM}, 32'h2);
      checkOutput("fieldWdata", io_wMemData_MEM, 32'h1234);
      checkOutput("fieldSrc", {31'b0, io_wRegDataSrc_ctrl_uMEM_MEM}, 32'h1);
      checkOutput("fieldExt", {31'b0, io_memReadDataExt_ctrl_uMEM_MEM}, 32'h1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      tick();
      checkOutput("bubbleWeReg", {31'b0, io_weReg_ctrl_MEM}, 32'h0);
      checkOutput("bubbleAlu", io_aluResult_MEM, 32'h55);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(1'b1, 32'h1, 32'h0, 1'b0, 1'b1, 2'd0, 5'd3);
      tick();
      io_ready_MEM = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 5'd0);
      repeat (20) tick();
      checkOutput("satCnt", {28'b0, io_stallCnt}, 32'hF);
      checkOutput("satAlu", io_aluResult_MEM, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midRstValid", {31'b0, io_valid_MEM}, 32'h0);
      checkOutput("midRstAlu", io_aluResult_MEM, 32'h0);
      checkOutput("midRstAddr", {27'b0, io_wRegAddr_MEM}, 32'h0);
      checkOutput("midRstCnt", {28'b0, io_stallCnt}, 32'h0);
      checkOutput("midRstReady", {31'b0, io_ready_EX}, 32'h1);
      tick();
      checkOutput("postRstReady", {31'b0, io_ready_EX}, 32'h1);
      checkOutput("postRstValid", {31'b0, io_valid_MEM}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
